data_tx_framer: RTL and testbench

//  Transmit-side framer: sources the 10-bit data_rx symbol stream that subcomponent consumes.

---
 rtl/tx_sym_pkg.sv | 42 ++++
 rtl/tx_sym_fifo.sv | 65 ++++++
 rtl/data_tx_framer.sv | 140 ++++++++++++++
 tb/tb_data_tx_framer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sym_pkg.sv
// Symbol codes, FSM state type and symbol packing shared by the tx framer.
// Build option TX_PARITY_EN: when defined, bit 8 of every symbol is even parity over bits 7:0.
package tx_sym_pkg;

    localparam logic [7:0] CodeIdle = 8'hBC;
    localparam logic [7:0] CodeSof  = 8'hFB;
    localparam logic [7:0] CodeEof  = 8'hFD;
    localparam logic [7:0] CodeFill = 8'hF7;

`ifdef TX_PARITY_EN
    localparam logic ParityEn = 1'b1;
`else
    localparam logic ParityEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StSof,
        StData,
        StEof,
        StGap
    } tx_state_e;

    typedef struct packed {
        logic       k;
        logic       par;
        logic [7:0] data;
    } symbol_t;

    function automatic logic sym_parity(input logic [7:0] data);
        return ParityEn & (^data);
    endfunction

    function automatic symbol_t sym_make(input logic k, input logic [7:0] data);
        symbol_t s;
        s.k    = k;
        s.par  = sym_parity(data);
        s.data = data;
        return s;
    endfunction

endpackage

// File: rtl/tx_sym_fifo.sv
// Synchronous payload FIFO holding {last, data} entries; synchronous active-low reset flushes it.
module tx_sym_fifo
    import tx_sym_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [8:0] wdata,
    output logic [8:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = AW + 1;

    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [8:0]      mem_q [DEPTH];
    logic [8:0]      mem_d [DEPTH];
    logic            do_push, do_pop;

    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            // power-of-two depth: natural pointer overflow is the wrap
            wptr_d        = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/data_tx_framer.sv
// Transmit framer: buffers payload bytes and emits one registered 10-bit symbol per clock
// (IDLE, SOF, payload, FILL, EOF). Build option TX_PARITY_EN enables the parity bit.
module data_tx_framer
    import tx_sym_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned IDLE_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic [9:0] data_tx,
    output logic       busy,
    output logic       trunc_err
);

    localparam int unsigned GapW = $clog2(IDLE_GAP + 1);

    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [8:0] fifo_rdata;

    tx_state_e     state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic          last_q, last_d;
    symbol_t       sym_q, sym_d;
    logic          busy_q, busy_d;
    logic          trunc_q, trunc_d;
    logic          start;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    tx_sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_last, in_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        start    = !fifo_empty && enable;
        state_d  = state_q;
        len_d    = len_q;
        gap_d    = gap_q;
        last_d   = last_q;
        sym_d    = sym_make(1'b1, CodeIdle);
        trunc_d  = 1'b0;
        fifo_pop = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSof;
                    sym_d   = sym_make(1'b1, CodeSof);
                    len_d   = '0;
                    last_d  = 1'b0;
                end
            end
            // SOF on the line now behaves like a DATA slot with nothing popped yet
            StSof, StData: begin
                if (last_q || (len_q == 8'(MAX_LEN))) begin
                    state_d = StEof;
                    sym_d   = sym_make(1'b1, CodeEof);
                    trunc_d = !last_q;
                end else if (!fifo_empty) begin
                    state_d  = StData;
                    fifo_pop = 1'b1;
                    sym_d    = sym_make(1'b0, fifo_rdata[7:0]);
                    len_d    = len_q + 8'd1;
                    last_d   = fifo_rdata[8];
                end else begin
                    state_d = StData;
                    sym_d   = sym_make(1'b1, CodeFill);
                end
            end
            StEof: begin
                state_d = StGap;
                gap_d   = GapW'(IDLE_GAP);
            end
            StGap: begin
                // gap_q counts IDLE symbols still owed, including the one now on the line
                if (gap_q <= GapW'(1)) begin
                    gap_d = '0;
                    if (start) begin
                        state_d = StSof;
                        sym_d   = sym_make(1'b1, CodeSof);
                        len_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            gap_q   <= '0;
            last_q  <= 1'b0;
            sym_q   <= sym_make(1'b1, CodeIdle);
            busy_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            sym_q   <= sym_d;
            busy_q  <= busy_d;
            trunc_q <= trunc_d;
        end
    end

    assign data_tx   = sym_q;
    assign busy      = busy_q;
    assign trunc_err = trunc_q;

endmodule

// File: tb/tb_data_tx_framer.sv
// Bench for data_tx_framer: directed scenarios plus random traffic against a queue-based model.
module tb_data_tx_framer;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned MAX_LEN    = 16;
    localparam int unsigned IDLE_GAP   = 2;
`ifdef TX_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy, trunc_err;
    logic [9:0] data_tx;

    always #5 clk = ~clk;

    data_tx_framer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_LEN    (MAX_LEN),
        .IDLE_GAP   (IDLE_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .data_tx   (data_tx),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    int trunc_cnt = 0;

    // Reference model state
    logic [8:0] mq[$];
    logic [9:0] exp_sym;
    logic       exp_busy, exp_trunc;
    bit         in_frame, f_last, eof_now, acc;
    int         f_len, idle_run;

    function automatic logic [9:0] sym(input logic k, input logic [7:0] d);
        return {k, PAR & (^d), d};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented to that edge.
    task automatic model_step();
        logic [8:0] e;
        acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            exp_sym   = sym(1'b1, 8'hBC);
            exp_trunc = 1'b0;
            in_frame  = 1'b0;
            eof_now   = 1'b0;
            idle_run  = IDLE_GAP + 1;
        end else begin
            acc       = in_valid && (mq.size() < FIFO_DEPTH);
            exp_trunc = 1'b0;
            if (eof_now) begin
                exp_sym  = sym(1'b1, 8'hBC);
                eof_now  = 1'b0;
                idle_run = 1;
            end else if (in_frame) begin
                if (f_last || f_len == MAX_LEN) begin
                    exp_sym   = sym(1'b1, 8'hFD);
                    exp_trunc = !f_last;
                    in_frame  = 1'b0;
                    eof_now   = 1'b1;
                end else if (mq.size() > 0) begin
                    e       = mq.pop_front();
                    exp_sym = sym(1'b0, e[7:0]);
                    f_len++;
                    f_last  = e[8];
                end else begin
                    exp_sym = sym(1'b1, 8'hF7);
                end
            end else if (mq.size() > 0 && enable && idle_run >= IDLE_GAP) begin
                exp_sym  = sym(1'b1, 8'hFB);
                in_frame = 1'b1;
                f_len    = 0;
                f_last   = 1'b0;
            end else begin
                exp_sym = sym(1'b1, 8'hBC);
                if (idle_run <= IDLE_GAP) idle_run++;
            end
            if (acc) mq.push_back({in_last, in_data});
        end
        exp_busy = rst_n && (in_frame || eof_now || (idle_run <= IDLE_GAP));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("data_tx", 32'(data_tx), 32'(exp_sym));
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("trunc_err", 32'(trunc_err), 32'(exp_trunc));
        check_eq("in_ready", 32'(in_ready), 32'(mq.size() < FIFO_DEPTH));
        if (trunc_err === 1'b1) trunc_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: byte 0x%0h not accepted in %0d cycles", d, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic frame_123();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check_eq("sof_at_e1", 32'(data_tx), 32'(sym(1'b1, 8'hFB)));
        send_byte(8'h33, 1'b1);
        check_eq("byte_at_e2", 32'(data_tx), 32'(sym(1'b0, 8'h11)));
        idle(8);
    endtask

    initial begin
        int t0, n;

        // 1: reset then idle
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);

        // 2: back-to-back 3-byte frame
        frame_123();

        // 3: underrun produces FILL
        send_byte(8'h44, 1'b0);
        idle(4);
        send_byte(8'h55, 1'b1);
        idle(8);

        // 4: truncation at MAX_LEN, remainder forms a second frame
        t0 = trunc_cnt;
        for (int i = 1; i <= 20; i++) send_byte(8'(i), i == 20);
        idle(30);
        check_eq("trunc_count", 32'(trunc_cnt - t0), 32'd1);

        // 5: backpressure with enable low
        enable = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hA4;
        in_last  = 1'b1;
        idle(3);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        check_eq("full_idle", 32'(data_tx), 32'(sym(1'b1, 8'hBC)));
        enable = 1'b1;
        send_byte(8'hA4, 1'b1);
        idle(15);

        // 6: reset after two payload bytes, no EOF afterwards
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        n = 0;
        while (!(in_frame && f_len == 2) && n < 50) begin
            tick();
            n++;
        end
        check_eq("mid_frame_reached", 32'(f_len), 32'd2);
        rst_n = 1'b0;
        tick();
        check_eq("rst_idle", 32'(data_tx), 32'(sym(1'b1, 8'hBC)));
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        idle(6);
        frame_123();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'($urandom);
            in_last  = ($urandom_range(0, 6) == 0);
            tick();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
